// File: rtl/cmt_pkg.sv
// Shared types and constants for the CMT FSK encoder.
// State enum, frame geometry and per-phase waveform tables.
package cmt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    START,
    DATA,
    STOP
  } state_t;

  localparam int FRAME_BITS = 11;
  localparam int STOP_BITS  = 2;

  // Indexed by phase 0..3: '0' = 1,1,0,0 and '1' = 1,0,1,0
  localparam logic [3:0] WAVE_ZERO = 4'b0011;
  localparam logic [3:0] WAVE_ONE  = 4'b0101;

  function automatic logic wave_at(
    input logic       b,
    input logic [1:0] ph
  );
    return b ? WAVE_ONE[ph] : WAVE_ZERO[ph];
  endfunction

endpackage

// File: rtl/cmt_bit_shaper.sv
// Quarter/phase timing and waveform lookup for one FSK bit stream.
// In: clk_sys, reset, start, bit_val, q_len. Out: wave, bit_done.
module cmt_bit_shaper
  import cmt_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic        bit_val,
  input  logic [12:0] q_len,
  output logic        wave,
  output logic        bit_done
);

  logic        active;
  logic [12:0] qcnt;
  logic [1:0]  phase;
  logic        q_end;

  assign q_end    = (qcnt == q_len - 13'd1);
  assign bit_done = active & q_end & (phase == 2'd3);

  // start is a level: while high the shaper runs, and
  // bit_val must already hold the bit for the next cycle.
  always_ff @(posedge clk_sys) begin
    if (reset || !start) begin
      active <= 1'b0;
      qcnt   <= '0;
      phase  <= '0;
      wave   <= 1'b0;
    end else if (!active) begin
      active <= 1'b1;
      qcnt   <= '0;
      phase  <= '0;
      wave   <= wave_at(bit_val, 2'd0);
    end else if (q_end) begin
      qcnt   <= '0;
      phase  <= phase + 2'd1;
      wave   <= wave_at(bit_val, phase + 2'd1);
    end else begin
      qcnt   <= qcnt + 13'd1;
      wave   <= wave_at(bit_val, phase);
    end
  end

endmodule

// File: rtl/cmt_fsk_encoder.sv
// MSX cassette FSK encoder: bytes and leader tones to cmt_out.
// In: clk_sys, reset, motor, baud_sel, hdr_req/long, tx_data/valid. Out: tx_ready, busy, cmt_out.
module cmt_fsk_encoder
  import cmt_pkg::*;
#(
  parameter int QDIV      = 4474,
  parameter int LONG_HDR  = 8000,
  parameter int SHORT_HDR = 2000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       motor,
  input  logic       baud_sel,
  input  logic       hdr_req,
  input  logic       hdr_long,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       cmt_out
);

  if (LONG_HDR > 16383 || SHORT_HDR > 16383 ||
      LONG_HDR < 1 || SHORT_HDR < 1) begin : g_bad_hdr
    $error("header length out of 14-bit counter range");
  end
  if (QDIV > 8191 || QDIV < 2) begin : g_bad_qdiv
    $error("QDIV out of 13-bit quarter counter range");
  end
  if (FRAME_BITS != 1 + 8 + STOP_BITS) begin : g_bad_frame
    $error("frame geometry inconsistent");
  end

  localparam logic [12:0] Q_SLOW  = 13'(QDIV);
  localparam logic [12:0] Q_FAST  = 13'(QDIV >> 1);
  localparam logic [13:0] N_LONG  = 14'(LONG_HDR);
  localparam logic [13:0] N_SHORT = 14'(SHORT_HDR);
  localparam logic [1:0]  STOP_LAST = 2'(STOP_BITS - 1);

  state_t      state;
  logic [7:0]  shreg;
  logic [2:0]  idx;
  logic [1:0]  stop_cnt;
  logic [13:0] hdr_cnt;
  logic [13:0] hdr_len;
  logic [12:0] q_len;
  logic        idle;
  logic        acc_hdr;
  logic        acc_tx;
  logic        last;
  logic        run;
  logic        bit_val;
  logic        bit_done;

  assign idle    = (state == IDLE);
  assign acc_hdr = idle & motor & hdr_req;
  assign acc_tx  = idle & motor & ~hdr_req & tx_valid;
  assign tx_ready = idle & motor & ~hdr_req & ~reset;

  assign last = bit_done &
    (((state == HDR) && (hdr_cnt == hdr_len - 14'd1)) ||
     ((state == STOP) && (stop_cnt == STOP_LAST)));

  // Shaper runs from the acceptance edge until the last bit ends.
  assign run = motor & (idle ? (acc_hdr | acc_tx) : ~last);

  // Bit for the coming cycle; at a bit boundary this is the next bit.
  always_comb begin
    bit_val = 1'b0;
    unique case (state)
      IDLE:  bit_val = acc_hdr;
      HDR:   bit_val = 1'b1;
      START: bit_val = bit_done ? shreg[0] : 1'b0;
      DATA: begin
        if (!bit_done)        bit_val = shreg[0];
        else if (idx == 3'd7) bit_val = 1'b1;
        else                  bit_val = shreg[1];
      end
      STOP:  bit_val = 1'b1;
      default: bit_val = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset || !motor) begin
      state    <= IDLE;
      busy     <= 1'b0;
      shreg    <= '0;
      idx      <= '0;
      stop_cnt <= '0;
      hdr_cnt  <= '0;
      hdr_len  <= '0;
      q_len    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc_hdr) begin
            state   <= HDR;
            busy    <= 1'b1;
            hdr_cnt <= '0;
            hdr_len <= hdr_long ? N_LONG : N_SHORT;
            q_len   <= baud_sel ? Q_FAST : Q_SLOW;
          end else if (acc_tx) begin
            state    <= START;
            busy     <= 1'b1;
            shreg    <= tx_data;
            idx      <= '0;
            stop_cnt <= '0;
            q_len    <= baud_sel ? Q_FAST : Q_SLOW;
          end
        end
        HDR: begin
          if (last) begin
            state   <= IDLE;
            busy    <= 1'b0;
            hdr_cnt <= '0;
          end else if (bit_done && hdr_cnt != 14'h3FFF) begin
            hdr_cnt <= hdr_cnt + 14'd1;
          end
        end
        START: begin
          if (bit_done) state <= DATA;
        end
        DATA: begin
          if (bit_done) begin
            shreg <= {1'b0, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (last) begin
            state    <= IDLE;
            busy     <= 1'b0;
            stop_cnt <= '0;
          end else if (bit_done) begin
            stop_cnt <= stop_cnt + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  cmt_bit_shaper u_shaper (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (run),
    .bit_val  (bit_val),
    .q_len    (q_len),
    .wave     (cmt_out),
    .bit_done (bit_done)
  );

endmodule

// File: tb/tb_cmt_fsk_encoder.sv
// Self-checking bench for cmt_fsk_encoder.
// Sequence-level waveform model plus literal frame/header checks.
module tb_cmt_fsk_encoder;

  localparam int QD = 8;
  localparam int LH = 6;
  localparam int SH = 3;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       motor;
  logic       baud_sel;
  logic       hdr_req;
  logic       hdr_long;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       cmt_out;

  cmt_fsk_encoder #(
    .QDIV      (QD),
    .LONG_HDR  (LH),
    .SHORT_HDR (SH)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .motor    (motor),
    .baud_sel (baud_sel),
    .hdr_req  (hdr_req),
    .hdr_long (hdr_long),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .cmt_out  (cmt_out)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors = 0;
  int miscompares = 0;
  int nprint = 0;

  logic mq[$];
  logic exp_out = 1'b0;
  logic exp_busy = 1'b0;
  bit   chk_en = 1'b0;

  function automatic void add_bit(input logic b, input int qq);
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < qq; k++)
        mq.push_back(b ? ((p % 2) == 0) : (p < 2));
  endfunction

  // Model: expand each accepted header/frame into its full
  // per-cycle output sequence, then play it back.
  always @(posedge clk_sys) begin
    int qq;
    int n;
    if (reset || !motor) begin
      mq.delete();
    end else if (!exp_busy && mq.size() == 0) begin
      qq = baud_sel ? QD / 2 : QD;
      if (hdr_req) begin
        n = hdr_long ? LH : SH;
        for (int i = 0; i < n; i++) add_bit(1'b1, qq);
      end else if (tx_valid) begin
        add_bit(1'b0, qq);
        for (int i = 0; i < 8; i++) add_bit(tx_data[i], qq);
        add_bit(1'b1, qq);
        add_bit(1'b1, qq);
      end
    end
    if (mq.size() > 0) begin
      exp_out  = mq.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_out  = 1'b0;
      exp_busy = 1'b0;
    end
  end

  logic cap[$];
  int   run = 0;
  int   gap = 1000;
  int   dec_bl = 32;
  int   run_hist[$];
  int   gap_hist[$];
  int   dec_hist[$];

  function automatic int decode();
    int d = 0;
    for (int i = 0; i < 16; i++)
      if (i * dec_bl + dec_bl / 4 < cap.size())
        d[i] = ~cap[i * dec_bl + dec_bl / 4];
    return d;
  endfunction

  always @(negedge clk_sys) begin
    logic er;
    if (chk_en) begin
      er = !reset && motor && !hdr_req && !exp_busy;
      vectors++;
      if (cmt_out !== exp_out || busy !== exp_busy ||
          tx_ready !== er) begin
        miscompares++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL cycle @%0t: out/busy/rdy = %b%b%b, required %b%b%b",
                   $time, cmt_out, busy, tx_ready, exp_out, exp_busy, er);
        end
      end
      if (busy === 1'b1) begin
        if (run == 0) gap_hist.push_back(gap);
        run++;
        cap.push_back(cmt_out);
      end else begin
        if (run > 0) begin
          run_hist.push_back(run);
          dec_hist.push_back(decode());
          run = 0;
          cap.delete();
          gap = 0;
        end
        gap++;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_busy || mq.size() != 0) && g < 5000) begin
      cyc(1);
      g++;
    end
    if (g >= 5000) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: busy after %0d cycles, required idle", g);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic bs);
    wait_idle();
    tx_data  = b;
    baud_sel = bs;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    motor = 1'b1;
    baud_sel = 1'b0;
    hdr_req = 1'b0;
    hdr_long = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    @(negedge clk_sys);
    check("reset cmt_out", int'(cmt_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset tx_ready", int'(tx_ready), 0);
    cyc(1);
    reset = 1'b0;
    cyc(2);

    // Byte 0x00 at 1200 baud
    dec_bl = 32;
    send(8'h00, 1'b0);
    @(negedge clk_sys);
    check("latency cmt_out", int'(cmt_out), 1);
    check("latency busy", int'(busy), 1);
    wait_idle();
    cyc(2);
    check("0x00 busy len", run_hist[$], 352);
    check("0x00 bits", dec_hist[$], 'h600);

    // Back-to-back frames
    send(8'hA5, 1'b0);
    send(8'h3C, 1'b0);
    wait_idle();
    cyc(2);
    check("0xA5 bits", dec_hist[$-1], 'h74A);
    check("0x3C bits", dec_hist[$], 'h678);
    check("b2b gap", gap_hist[$], 1);

    // Long header at 2400 baud; baud change mid-header ignored
    dec_bl = 16;
    wait_idle();
    hdr_req = 1'b1;
    hdr_long = 1'b1;
    baud_sel = 1'b1;
    cyc(1);
    hdr_req = 1'b0;
    baud_sel = 1'b0;
    wait_idle();
    cyc(2);
    check("long hdr len", run_hist[$], 96);
    check("long hdr bits", dec_hist[$], 'h3F);

    // Header and byte in the same cycle
    dec_bl = 32;
    hdr_req = 1'b1;
    hdr_long = 1'b0;
    baud_sel = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h5A;
    cyc(1);
    hdr_req = 1'b0;
    wait_idle();
    cyc(1);
    tx_valid = 1'b0;
    wait_idle();
    cyc(2);
    check("short hdr len", run_hist[$-1], 96);
    check("short hdr bits", dec_hist[$-1], 'h7);
    check("hdr->byte gap", gap_hist[$], 1);
    check("0x5A len", run_hist[$], 352);
    check("0x5A bits", dec_hist[$], 'h6B4);

    // Motor dropped in data bit 4
    send(8'hFF, 1'b0);
    cyc(170);
    motor = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("motor off cmt_out", int'(cmt_out), 0);
    check("motor off busy", int'(busy), 0);
    check("motor off tx_ready", int'(tx_ready), 0);
    cyc(3);
    motor = 1'b1;
    cyc(2);
    check("cut frame len", run_hist[$], 171);
    send(8'h81, 1'b0);
    wait_idle();
    cyc(2);
    check("0x81 len", run_hist[$], 352);
    check("0x81 bits", dec_hist[$], 'h702);

    // Reset in the first stop bit
    send(8'h00, 1'b0);
    cyc(300);
    reset = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("mid reset cmt_out", int'(cmt_out), 0);
    check("mid reset busy", int'(busy), 0);
    check("mid reset tx_ready", int'(tx_ready), 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    send(8'h0F, 1'b0);
    @(negedge clk_sys);
    check("post reset cmt_out", int'(cmt_out), 1);
    wait_idle();
    cyc(2);
    check("0x0F bits", dec_hist[$], 'h61E);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
